btn_input_conditioner: RTL and testbench
========================================

Name: btn_input_conditioner

Overview:
- Front end for the board inputs that feed the game FSM (five push-buttons, nine card-select switches).
- Synchronises and debounces every raw input. Produces one-cycle button pulses with a one-button-at-a-time lockout.
- Qualifies the switch word as a legal single-card selection and emits its card index.
- Sits between the top-level pins and the game FSM. The FSM consumes only these outputs, never the raw pins.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles an input must stay stable before it is accepted (10 ms at 100 MHz); legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_raw  in  5  raw buttons: [0] center, [1] top, [2] bottom, [3] left, [4] right.
- sw_raw  in  9  raw card-select switches sw[8:0].
- btn_pulse  out  5  one-cycle accepted-press pulse, same bit order as btn_raw; at most one bit high.
- btn_level  out  5  debounced button levels.
- sw_stable  out  9  debounced switch word.
- sw_onehot  out  1  sw_stable has exactly one bit set.
- card_idx  out  4  bit position (0..8) of the set switch when sw_onehot=1, else 4'hF.
- sw_changed  out  1  one-cycle pulse whenever sw_stable changes.

Behaviour:
- Reset (async assert, sync release):
  - Synchronisers, stable levels and counters go to 0.
  - btn_pulse, btn_level, sw_stable, sw_onehot and sw_changed go to 0; card_idx goes to 4'hF.
  - Arbiter goes to READY.
- Per input (14 cells): 2-flop synchroniser, then a debounce counter.
  - sync == stable: counter clears to 0.
  - sync != stable: counter increments. When it reaches DEBOUNCE_CYCLES-1, stable takes the sync value and the counter clears.
  - A raw level held from sampling edge E is reflected in stable at edge E+2+DEBOUNCE_CYCLES-1.
  - Any glitch shorter than DEBOUNCE_CYCLES synced cycles leaves stable unchanged and restarts the count.
- Rise detect: rise[i] = stable[i] & ~stable_d[i], using a registered copy of the stable levels.
- Arbiter FSM (2 states):
  - READY: if any rise, register btn_pulse with only the highest-priority risen bit (center > top > bottom > left > right), then go to HELD. Otherwise btn_pulse = 0.
  - HELD: btn_pulse = 0. Return to READY only in a cycle where btn_level == 0.
  - Buttons that rise during HELD are discarded. A button already held when READY is re-entered never pulses (rise only).
- btn_pulse is registered: high exactly one cycle, one cycle after the stable rise. A held button gives exactly one pulse.
- Switch qualification, registered from sw_stable (one cycle after sw_stable updates):
  - sw_onehot = popcount == 1.
  - card_idx = position of the set bit when one-hot, else 4'hF. All-zero and multi-bit words are both invalid.
- sw_changed is high for one cycle, aligned with the updated sw_onehot/card_idx.
- Reset mid-count discards partial debounce progress and any pending pulse.

Decomposition:
- Shared package game_pkg:
  - Button index constants BTN_CENTER=0, BTN_TOP=1, BTN_BOTTOM=2, BTN_LEFT=3, BTN_RIGHT=4.
  - N_BTN=5, N_CARD=9, CARD_NONE=4'hF.
  - Arbiter state enum {ARB_READY, ARB_HELD}.
- Sub-module debounce_cell (synchroniser + counter + stable register, parameter DEBOUNCE_CYCLES), instantiated 14 times.
- Arbiter, switch qualifier and edge logic live in the top.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press: btn_raw[1] 0→1 held for 20 cycles:
  - btn_level[1] rises 5 cycles after the first sampling edge.
  - btn_pulse=5'b00010 for exactly 1 cycle, the next cycle.
  - No further pulse while held.
- Bounce: btn_raw[0] toggles 1,0,1,0 at 2-cycle intervals, then stays 0: btn_level and btn_pulse stay 0 throughout.
- Simultaneous press: top and left raised on the same edge and held:
  - Only btn_pulse=5'b00010 appears.
  - Release top, keep left: no pulse.
  - Release left, then press left again: btn_pulse=5'b01000 once.
- Switches:
  - sw_raw=9'b000010000 stable for 10 cycles: sw_stable=9'h010, sw_onehot=1, card_idx=4, one sw_changed pulse.
  - Then 9'b000010001: sw_onehot=0, card_idx=4'hF.
  - Then 0: card_idx=4'hF.
- Reset mid-operation: btn_raw[3]=1 for 3 cycles, assert reset_n=0 asynchronously, release it, keep btn_raw[3]=1:
  - All outputs go to reset values immediately.
  - After release, btn_pulse=5'b01000 appears once, with full latency counted from release.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, arbiter state type and card-index helper for the game front end.
package game_pkg;

   localparam int N_BTN  = 5;
   localparam int N_CARD = 9;

   localparam int BTN_CENTER = 0;
   localparam int BTN_TOP    = 1;
   localparam int BTN_BOTTOM = 2;
   localparam int BTN_LEFT   = 3;
   localparam int BTN_RIGHT  = 4;

   localparam logic [3:0] CARD_NONE = 4'hF;

   typedef enum logic {
      ARB_READY,
      ARB_HELD
   } arb_state_e;

   // Multi-bit and all-zero words are both illegal selections.
   function automatic logic [3:0] card_index(input logic [N_CARD-1:0] w);
      logic [3:0] idx;
      idx = CARD_NONE;
      if ($countones(w) == 1) begin
         for (int i = 0; i < N_CARD; i++) begin
            if (w[i]) idx = 4'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/btn_input_conditioner_if.sv
// Pin-side bundle: raw buttons/switches in, conditioned pulses, levels and card index out.
interface btn_input_conditioner_if;
   import game_pkg::*;

   logic [N_BTN-1:0]  btn_raw;
   logic [N_CARD-1:0] sw_raw;
   logic [N_BTN-1:0]  btn_pulse;
   logic [N_BTN-1:0]  btn_level;
   logic [N_CARD-1:0] sw_stable;
   logic              sw_onehot;
   logic [3:0]        card_idx;
   logic              sw_changed;

   modport master (
      output btn_raw, sw_raw,
      input  btn_pulse, btn_level, sw_stable, sw_onehot, card_idx, sw_changed
   );

   modport slave (
      input  btn_raw, sw_raw,
      output btn_pulse, btn_level, sw_stable, sw_onehot, card_idx, sw_changed
   );

endinterface

// File: rtl/debounce_cell.sv
// Two-flop synchroniser plus debounce counter; a level held from sampling edge E
// appears on stable_o at edge E+1+DEBOUNCE_CYCLES. No backpressure.
module debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_i,
   output logic stable_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any return to the stable value clears the count, so glitches restart it.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) stable_d = sync2_q;
         else                   cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/btn_input_conditioner.sv
// Debounces 5 buttons and 9 switches; one-at-a-time press pulses one cycle after the
// debounced rise, and a registered card index one cycle after the switch word settles.
module btn_input_conditioner
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   btn_input_conditioner_if.slave   bus
);

   logic [N_BTN-1:0]  btn_stable, btn_prev_q, rise;
   logic [N_CARD-1:0] sw_stable, sw_prev_q;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
         .clk      (clk),
         .reset_n  (reset_n),
         .raw_i    (bus.btn_raw[i]),
         .stable_o (btn_stable[i])
      );
   end

   for (genvar i = 0; i < N_CARD; i++) begin : g_sw
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
         .clk      (clk),
         .reset_n  (reset_n),
         .raw_i    (bus.sw_raw[i]),
         .stable_o (sw_stable[i])
      );
   end

   assign rise = btn_stable & ~btn_prev_q;

   arb_state_e       state_q, state_d;
   logic [N_BTN-1:0] pulse_q, pulse_d;

   // Lowest index wins, giving center > top > bottom > left > right.
   always_comb begin
      state_d = state_q;
      pulse_d = '0;
      case (state_q)
         ARB_READY: begin
            if (|rise) begin
               pulse_d = rise & (~rise + 1'b1);
               state_d = ARB_HELD;
            end
         end
         ARB_HELD: begin
            if (btn_stable == '0) state_d = ARB_READY;
         end
         default: state_d = ARB_READY;
      endcase
   end

   logic       onehot_q, changed_q;
   logic [3:0] idx_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ARB_READY;
         pulse_q    <= '0;
         btn_prev_q <= '0;
         sw_prev_q  <= '0;
         onehot_q   <= 1'b0;
         idx_q      <= CARD_NONE;
         changed_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pulse_q    <= pulse_d;
         btn_prev_q <= btn_stable;
         sw_prev_q  <= sw_stable;
         onehot_q   <= ($countones(sw_stable) == 1);
         idx_q      <= card_index(sw_stable);
         changed_q  <= (sw_stable != sw_prev_q);
      end
   end

   assign bus.btn_pulse  = pulse_q;
   assign bus.btn_level  = btn_stable;
   assign bus.sw_stable  = sw_stable;
   assign bus.sw_onehot  = onehot_q;
   assign bus.card_idx   = idx_q;
   assign bus.sw_changed = changed_q;

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Directed bench with scoreboards for button pulses and switch-change events.
module tb_btn_input_conditioner;
   import game_pkg::*;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   btn_input_conditioner_if bus();

   btn_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [8:0] sw;
      logic       onehot;
      logic [3:0] idx;
   } sw_exp_t;

   logic [4:0] exp_pulse_q[$];
   sw_exp_t    exp_sw_q[$];

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.btn_pulse !== 5'b0) begin
         if (exp_pulse_q.size() == 0) check("pulse_unexpected", 16'(bus.btn_pulse), 16'h0);
         else                         check("pulse_sb", 16'(bus.btn_pulse), 16'(exp_pulse_q.pop_front()));
      end
      if (reset_n === 1'b1 && bus.sw_changed !== 1'b0) begin
         if (exp_sw_q.size() == 0) begin
            check("sw_changed_unexpected", 16'(bus.sw_changed), 16'h0);
         end else begin
            sw_exp_t e;
            e = exp_sw_q.pop_front();
            check("sw_sb_stable", 16'(bus.sw_stable), 16'(e.sw));
            check("sw_sb_onehot", 16'(bus.sw_onehot), 16'(e.onehot));
            check("sw_sb_idx",    16'(bus.card_idx),  16'(e.idx));
         end
      end
   end

   initial begin
      reset_n     = 1'b0;
      bus.btn_raw = '0;
      bus.sw_raw  = '0;
      wait_cycles(3);
      check("rst_pulse",   16'(bus.btn_pulse),  16'h0);
      check("rst_level",   16'(bus.btn_level),  16'h0);
      check("rst_sw",      16'(bus.sw_stable),  16'h0);
      check("rst_onehot",  16'(bus.sw_onehot),  16'h0);
      check("rst_idx",     16'(bus.card_idx),   16'hF);
      check("rst_changed", 16'(bus.sw_changed), 16'h0);
      reset_n = 1'b1;
      wait_cycles(2);

      // Clean press of top
      bus.btn_raw = 5'b00010;
      exp_pulse_q.push_back(5'b00010);
      wait_cycles(5);
      check("press_level_early", 16'(bus.btn_level), 16'h0);
      wait_cycles(1);
      check("press_level", 16'(bus.btn_level), 16'h02);
      check("press_pulse_early", 16'(bus.btn_pulse), 16'h0);
      wait_cycles(1);
      check("press_pulse", 16'(bus.btn_pulse), 16'h02);
      wait_cycles(1);
      check("press_pulse_once", 16'(bus.btn_pulse), 16'h0);
      wait_cycles(12);
      check("press_sb_drained", 16'(exp_pulse_q.size()), 16'h0);
      bus.btn_raw = '0;
      wait_cycles(10);
      check("release_level", 16'(bus.btn_level), 16'h0);

      // Bounce on center, never stable long enough
      for (int i = 0; i < 4; i++) begin
         bus.btn_raw[BTN_CENTER] = (i % 2 == 0);
         repeat (2) begin
            @(negedge clk);
            check("bounce_level", 16'(bus.btn_level), 16'h0);
         end
      end
      bus.btn_raw = '0;
      repeat (8) begin
         @(negedge clk);
         check("bounce_settle", 16'(bus.btn_level), 16'h0);
      end

      // Simultaneous top + left: top wins, left is locked out
      bus.btn_raw = 5'b01010;
      exp_pulse_q.push_back(5'b00010);
      wait_cycles(7);
      check("simul_pulse", 16'(bus.btn_pulse), 16'h02);
      wait_cycles(5);
      check("simul_level", 16'(bus.btn_level), 16'h0A);
      bus.btn_raw = 5'b01000;
      wait_cycles(12);
      check("simul_left_level", 16'(bus.btn_level), 16'h08);
      check("simul_no_left", 16'(exp_pulse_q.size()), 16'h0);
      bus.btn_raw = '0;
      wait_cycles(10);
      bus.btn_raw = 5'b01000;
      exp_pulse_q.push_back(5'b01000);
      wait_cycles(7);
      check("left_pulse", 16'(bus.btn_pulse), 16'h08);
      wait_cycles(5);
      bus.btn_raw = '0;
      wait_cycles(10);

      // Switch qualification
      bus.sw_raw = 9'h010;
      exp_sw_q.push_back('{sw: 9'h010, onehot: 1'b1, idx: 4'd4});
      wait_cycles(10);
      check("sw10_stable", 16'(bus.sw_stable), 16'h010);
      check("sw10_onehot", 16'(bus.sw_onehot), 16'h1);
      check("sw10_idx",    16'(bus.card_idx),  16'h4);
      bus.sw_raw = 9'h011;
      exp_sw_q.push_back('{sw: 9'h011, onehot: 1'b0, idx: 4'hF});
      wait_cycles(10);
      check("sw11_onehot", 16'(bus.sw_onehot), 16'h0);
      check("sw11_idx",    16'(bus.card_idx),  16'hF);
      bus.sw_raw = 9'h100;
      exp_sw_q.push_back('{sw: 9'h100, onehot: 1'b1, idx: 4'd8});
      wait_cycles(10);
      check("sw100_idx", 16'(bus.card_idx), 16'h8);
      bus.sw_raw = 9'h000;
      exp_sw_q.push_back('{sw: 9'h000, onehot: 1'b0, idx: 4'hF});
      wait_cycles(10);
      check("sw0_idx",    16'(bus.card_idx),  16'hF);
      check("sw0_onehot", 16'(bus.sw_onehot), 16'h0);
      bus.sw_raw = 9'h004;
      exp_sw_q.push_back('{sw: 9'h004, onehot: 1'b1, idx: 4'd2});
      wait_cycles(10);
      check("sw4_idx", 16'(bus.card_idx), 16'h2);
      check("sw_sb_drained", 16'(exp_sw_q.size()), 16'h0);

      // Asynchronous reset in the middle of a left press
      bus.btn_raw = 5'b01000;
      wait_cycles(3);
      #2 reset_n = 1'b0;
      #1;
      check("arst_pulse",   16'(bus.btn_pulse),  16'h0);
      check("arst_level",   16'(bus.btn_level),  16'h0);
      check("arst_sw",      16'(bus.sw_stable),  16'h0);
      check("arst_onehot",  16'(bus.sw_onehot),  16'h0);
      check("arst_idx",     16'(bus.card_idx),   16'hF);
      check("arst_changed", 16'(bus.sw_changed), 16'h0);
      wait_cycles(2);
      reset_n = 1'b1;
      exp_pulse_q.push_back(5'b01000);
      exp_sw_q.push_back('{sw: 9'h004, onehot: 1'b1, idx: 4'd2});
      wait_cycles(5);
      check("arst_level_early", 16'(bus.btn_level), 16'h0);
      wait_cycles(1);
      check("arst_level_up", 16'(bus.btn_level), 16'h08);
      wait_cycles(1);
      check("arst_pulse_after", 16'(bus.btn_pulse), 16'h08);
      wait_cycles(1);
      check("arst_pulse_once", 16'(bus.btn_pulse), 16'h0);
      wait_cycles(10);
      check("final_pulse_sb", 16'(exp_pulse_q.size()), 16'h0);
      check("final_sw_sb",    16'(exp_sw_q.size()),    16'h0);
      check("final_idx",      16'(bus.card_idx),       16'h2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
